bus_addr_serializer: RTL and testbench
======================================

# bus_addr_serializer

Master-side address transmitter for the serial bus. Accepts a slave ID and memory address from the master core, arbitrates for the bus, then shifts the slave ID and memory address out LSB-first on the shared serial line with the bus-utilisation and address-phase strobes. It is the initiating end of the address phase consumed by the slave-side address decoder, and aborts cleanly when the split-capable slave reports busy.

## Interface
- SLV_BITS, 2, slave ID width; ID 0 is invalid, ID 1 is the split-capable slave.
- MEM_ADDR_WIDTH, 12, memory address width (4K slave space).

- CLK  in  1  bus clock, all logic on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- M_REQ  in  1  master request; sampled only while M_RDY=1.
- M_SLAVE  in  SLV_BITS  target slave ID, captured with M_REQ.
- M_ADDR  in  MEM_ADDR_WIDTH  target memory address, captured with M_REQ.
- M_RDY  out  1  high in IDLE only.
- M_DONE  out  1  one-cycle pulse: address phase completed.
- M_SPLIT  out  1  one-cycle pulse: aborted, split slave busy.
- M_ERR  out  1  one-cycle pulse: request rejected, slave ID 0.
- B_REQ  out  1  bus request to arbiter.
- B_GRANT  in  1  bus grant from arbiter.
- B_UTIL  out  1  bus in use by this master.
- A_ADD  out  1  address bit valid on B_BUS_OUT.
- B_BUS_OUT  out  1  serial address data.
- B_SBSY  in  1  split slave busy.

## Operation
- States: IDLE, ARB, SLV, CHK, ADDR.
- IDLE: M_RDY=1. On M_REQ=1: capture M_SLAVE/M_ADDR into shift registers, clear bit counter. If M_SLAVE=0: pulse M_ERR, stay IDLE, no B_REQ. Else go ARB.
- ARB: B_REQ=1 until B_GRANT=1, then go SLV. No timeout; waits indefinitely.
- SLV: B_UTIL=1, A_ADD=1, B_BUS_OUT = slave ID bit[count], LSB first, SLV_BITS cycles; then CHK.
- CHK: one cycle, B_UTIL=1, A_ADD=0, B_BUS_OUT=0 (decoder validation slot). If captured ID=1 and B_SBSY=1: pulse M_SPLIT, go IDLE. Else go ADDR.
- ADDR: B_UTIL=1, A_ADD=1, B_BUS_OUT = address bit[count], LSB first, MEM_ADDR_WIDTH cycles; after last bit pulse M_DONE, go IDLE.
- B_REQ deasserts on the cycle SLV is entered; B_GRANT ignored outside ARB.
- M_REQ outside IDLE ignored (not queued). Captured values unaffected by input changes after capture.
- B_SBSY ignored outside CHK and for IDs 2, 3.

## Timing
- All outputs registered; no combinational input-to-output paths.
- Reset: state IDLE, M_RDY=1, all other outputs 0, counter 0, shift registers 0. RSTN low mid-transaction forces these values immediately (async); bus released same cycle, no M_DONE/M_SPLIT pulse.
- M_REQ sampled at edge 0 → B_REQ high cycle 1. With B_GRANT already high at cycle 1: SLV cycles 2-3, CHK cycle 4, ADDR cycles 5-16, M_DONE and M_RDY high cycle 17, B_UTIL low cycle 17.
- M_ERR: high the cycle after M_REQ sampling; M_RDY stays 1.
- M_SPLIT: high cycle after CHK (cycle 5 with immediate grant), B_UTIL low same cycle.
- Back-to-back: M_REQ may be accepted in the cycle M_DONE is high; next B_REQ follows one cycle later.
- Counter width: clog2(max(SLV_BITS, MEM_ADDR_WIDTH)); cleared on SLV→CHK and CHK→ADDR; wraps never (bounded by state exit).

## Structure
- Shared bus package: state enum type, SLV_BITS/MEM_ADDR_WIDTH defaults, constants SLV_INVALID=0 and SLV_SPLIT=1.
- One sub-module: bit_counter (parameterised width, sync clear, increment enable, async active-low reset).
- Shift-out via index into captured registers or right-shift register; either acceptable, LSB-first ordering mandatory.

## Test plan
- Reset: RSTN low during ADDR bit 5 → next sample B_UTIL=0, A_ADD=0, M_RDY=1, no pulses; new request afterwards completes normally.
- Normal: M_SLAVE=2, M_ADDR=12'hA5C, grant immediate → B_BUS_OUT sequence 0,1 (SLV), 0 (CHK), then 0,0,1,1,1,0,1,0,0,1,0,1; M_DONE at cycle 17.
- Delayed grant: B_GRANT held low 5 cycles → B_REQ high 5 cycles, B_UTIL 0 throughout ARB, then normal sequence.
- Split abort: M_SLAVE=1, B_SBSY=1 in CHK → M_SPLIT pulse, no ADDR bits, M_RDY=1; repeat with B_SBSY=0 → M_DONE.
- Invalid ID: M_SLAVE=0 → M_ERR pulse next cycle, B_REQ never asserted.
- Busy ignore / back-to-back: M_REQ toggled during ADDR ignored; M_REQ asserted in M_DONE cycle → B_REQ one cycle later, second address correct.

Source files
------------

// File: rtl/bus_addr_serializer_pkg.sv
// Shared serial-bus definitions: address-phase FSM states, default widths,
// reserved slave IDs, and a helper that sizes the phase bit counter.
package bus_addr_serializer_pkg;

  localparam int unsigned DEF_SLV_BITS       = 2;
  localparam int unsigned DEF_MEM_ADDR_WIDTH = 12;

  // Slave ID 0 is never addressable; ID 1 may answer busy in the check slot.
  localparam int unsigned SLV_INVALID = 0;
  localparam int unsigned SLV_SPLIT   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SLV,
    ST_CHK,
    ST_ADDR
  } bus_state_e;

  // Counter must index the longest of the two shifted fields; never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bus_addr_serializer_bit_counter.sv
// Up-counter with synchronous clear (priority) and increment enable.
// Ports: CLK, RSTN (async active-low), clr, inc, cnt.
module bit_counter #(
  parameter int unsigned W = 4
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/bus_addr_serializer.sv
// Master-side serial address transmitter. Captures a slave ID and memory
// address, arbitrates for the bus, then shifts the ID, a one-cycle decoder
// check slot, and the address out LSB-first. Aborts when the split slave
// reports busy in the check slot.
// Ports:
//   CLK, RSTN                  clock, async active-low reset
//   M_REQ, M_SLAVE, M_ADDR     master request and target (sampled in IDLE)
//   M_RDY, M_DONE, M_SPLIT,    master status; DONE/SPLIT/ERR are 1-cycle pulses
//   M_ERR
//   B_REQ, B_GRANT             arbiter handshake
//   B_UTIL, A_ADD, B_BUS_OUT   bus in use, address-bit valid, serial data
//   B_SBSY                     split slave busy (looked at in the check slot)
module bus_addr_serializer
  import bus_addr_serializer_pkg::*;
#(
  parameter int unsigned SLV_BITS       = DEF_SLV_BITS,
  parameter int unsigned MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      M_REQ,
  input  logic [SLV_BITS-1:0]       M_SLAVE,
  input  logic [MEM_ADDR_WIDTH-1:0] M_ADDR,
  output logic                      M_RDY,
  output logic                      M_DONE,
  output logic                      M_SPLIT,
  output logic                      M_ERR,
  output logic                      B_REQ,
  input  logic                      B_GRANT,
  output logic                      B_UTIL,
  output logic                      A_ADD,
  output logic                      B_BUS_OUT,
  input  logic                      B_SBSY
);

  localparam int unsigned CNT_W = cnt_width(SLV_BITS, MEM_ADDR_WIDTH);

  localparam logic [CNT_W-1:0]    SLV_LAST  = CNT_W'(SLV_BITS - 1);
  localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(MEM_ADDR_WIDTH - 1);
  localparam logic [SLV_BITS-1:0] ID_INV    = SLV_BITS'(SLV_INVALID);
  localparam logic [SLV_BITS-1:0] ID_SPLIT  = SLV_BITS'(SLV_SPLIT);

  bus_state_e state_q, state_d;

  // slv_id_q keeps the untouched ID for the split check; the _sh copies shift.
  logic [SLV_BITS-1:0]       slv_id_q, slv_id_d;
  logic [SLV_BITS-1:0]       slv_sh_q, slv_sh_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;

  logic [CNT_W-1:0] cnt;
  logic             cnt_clr, cnt_inc;

  logic m_rdy_d, m_done_d, m_split_d, m_err_d;
  logic b_req_d, b_util_d, a_add_d, bus_d;

  // Counts the bit currently on the line within the SLV or ADDR phase.
  bit_counter #(
    .W (CNT_W)
  ) u_bit_counter (
    .CLK  (CLK),
    .RSTN (RSTN),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt)
  );

  // State, capture registers and registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      slv_id_q  <= '0;
      slv_sh_q  <= '0;
      addr_sh_q <= '0;
      M_RDY     <= 1'b1;
      M_DONE    <= 1'b0;
      M_SPLIT   <= 1'b0;
      M_ERR     <= 1'b0;
      B_REQ     <= 1'b0;
      B_UTIL    <= 1'b0;
      A_ADD     <= 1'b0;
      B_BUS_OUT <= 1'b0;
    end else begin
      state_q   <= state_d;
      slv_id_q  <= slv_id_d;
      slv_sh_q  <= slv_sh_d;
      addr_sh_q <= addr_sh_d;
      M_RDY     <= m_rdy_d;
      M_DONE    <= m_done_d;
      M_SPLIT   <= m_split_d;
      M_ERR     <= m_err_d;
      B_REQ     <= b_req_d;
      B_UTIL    <= b_util_d;
      A_ADD     <= a_add_d;
      B_BUS_OUT <= bus_d;
    end
  end

  // Next state and next output values; outputs describe the coming cycle.
  always_comb begin
    state_d   = state_q;
    slv_id_d  = slv_id_q;
    slv_sh_d  = slv_sh_q;
    addr_sh_d = addr_sh_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    m_rdy_d   = 1'b0;
    m_done_d  = 1'b0;
    m_split_d = 1'b0;
    m_err_d   = 1'b0;
    b_req_d   = 1'b0;
    b_util_d  = 1'b0;
    a_add_d   = 1'b0;
    bus_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        m_rdy_d = 1'b1;
        if (M_REQ) begin
          slv_id_d  = M_SLAVE;
          slv_sh_d  = M_SLAVE;
          addr_sh_d = M_ADDR;
          cnt_clr   = 1'b1;
          if (M_SLAVE == ID_INV) begin
            m_err_d = 1'b1;
          end else begin
            state_d = ST_ARB;
            m_rdy_d = 1'b0;
            b_req_d = 1'b1;
          end
        end
      end

      ST_ARB: begin
        if (B_GRANT) begin
          // First ID bit goes out in the very first SLV cycle.
          state_d  = ST_SLV;
          b_util_d = 1'b1;
          a_add_d  = 1'b1;
          bus_d    = slv_sh_q[0];
          slv_sh_d = slv_sh_q >> 1;
        end else begin
          b_req_d = 1'b1;
        end
      end

      ST_SLV: begin
        b_util_d = 1'b1;
        if (cnt == SLV_LAST) begin
          state_d = ST_CHK;
          cnt_clr = 1'b1;
        end else begin
          a_add_d  = 1'b1;
          bus_d    = slv_sh_q[0];
          slv_sh_d = slv_sh_q >> 1;
          cnt_inc  = 1'b1;
        end
      end

      ST_CHK: begin
        if ((slv_id_q == ID_SPLIT) && B_SBSY) begin
          state_d   = ST_IDLE;
          m_split_d = 1'b1;
          m_rdy_d   = 1'b1;
        end else begin
          state_d   = ST_ADDR;
          b_util_d  = 1'b1;
          a_add_d   = 1'b1;
          bus_d     = addr_sh_q[0];
          addr_sh_d = addr_sh_q >> 1;
          cnt_clr   = 1'b1;
        end
      end

      ST_ADDR: begin
        if (cnt == ADDR_LAST) begin
          state_d  = ST_IDLE;
          m_done_d = 1'b1;
          m_rdy_d  = 1'b1;
        end else begin
          b_util_d  = 1'b1;
          a_add_d   = 1'b1;
          bus_d     = addr_sh_q[0];
          addr_sh_d = addr_sh_q >> 1;
          cnt_inc   = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        m_rdy_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_addr_serializer.sv
// Bench for bus_addr_serializer: a frame-level reference model predicts every
// output cycle by cycle; directed transactions pin timing and bit order with
// literal values, then a randomized phase runs against the model.
module tb_bus_addr_serializer;

  localparam int SB = 2;
  localparam int AW = 12;
  localparam int FL = SB + 1 + AW;

  logic          CLK;
  logic          RSTN;
  logic          M_REQ;
  logic [SB-1:0] M_SLAVE;
  logic [AW-1:0] M_ADDR;
  logic          M_RDY, M_DONE, M_SPLIT, M_ERR;
  logic          B_REQ, B_GRANT, B_UTIL, A_ADD, B_BUS_OUT, B_SBSY;

  bus_addr_serializer #(
    .SLV_BITS       (SB),
    .MEM_ADDR_WIDTH (AW)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .M_REQ     (M_REQ),
    .M_SLAVE   (M_SLAVE),
    .M_ADDR    (M_ADDR),
    .M_RDY     (M_RDY),
    .M_DONE    (M_DONE),
    .M_SPLIT   (M_SPLIT),
    .M_ERR     (M_ERR),
    .B_REQ     (B_REQ),
    .B_GRANT   (B_GRANT),
    .B_UTIL    (B_UTIL),
    .A_ADD     (A_ADD),
    .B_BUS_OUT (B_BUS_OUT),
    .B_SBSY    (B_SBSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 arbitrating, 2 transferring frame[pos].
  // The frame is the whole serial image: ID bits, check slot, address bits.
  int       mode = 0;
  int       pos  = 0;
  bit       frame [0:FL-1];
  logic [SB-1:0] m_id;
  bit       e_done, e_split, e_err;

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mode = 0; pos = 0;
      e_done = 0; e_split = 0; e_err = 0;
    end else begin
      e_done = 0; e_split = 0; e_err = 0;
      case (mode)
        0: if (M_REQ) begin
          if (M_SLAVE == 0) e_err = 1;
          else begin
            m_id = M_SLAVE;
            for (int i = 0; i < SB; i++) frame[i] = M_SLAVE[i];
            frame[SB] = 0;
            for (int j = 0; j < AW; j++) frame[SB+1+j] = M_ADDR[j];
            mode = 1;
          end
        end
        1: if (B_GRANT) begin mode = 2; pos = 0; end
        default: begin
          if (pos == SB && m_id == 1 && B_SBSY) begin mode = 0; e_split = 1; end
          else if (pos == FL - 1) begin mode = 0; e_done = 1; end
          else pos++;
        end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge CLK) begin
    #1;
    if (chk_en) begin
      check("rdy",   32'(M_RDY),     32'(mode == 0));
      check("breq",  32'(B_REQ),     32'(mode == 1));
      check("util",  32'(B_UTIL),    32'(mode == 2));
      check("aadd",  32'(A_ADD),     32'(mode == 2 && pos != SB));
      check("bus",   32'(B_BUS_OUT), 32'((mode == 2) ? frame[pos] : 1'b0));
      check("done",  32'(M_DONE),    32'(e_done));
      check("split", 32'(M_SPLIT),   32'(e_split));
      check("err",   32'(M_ERR),     32'(e_err));
    end
  end

  // Per-transaction traces, bit k = value during cycle k after acceptance edge.
  logic [40:0] tr_bus, tr_add, tr_util, tr_req, tr_done, tr_split, tr_err, tr_rdy;

  task automatic txn(input logic [SB-1:0] slv, input logic [AW-1:0] addr, input int gdelay,
                     input logic sbsy, input int noise_end, input bit b2b,
                     input logic [SB-1:0] slv2, input logic [AW-1:0] addr2, input int rst_k);
    tr_bus = '0; tr_add = '0; tr_util = '0; tr_req = '0;
    tr_done = '0; tr_split = '0; tr_err = '0; tr_rdy = '0;
    @(negedge CLK);
    M_REQ = 1'b1; M_SLAVE = slv; M_ADDR = addr; B_GRANT = 1'b0; B_SBSY = sbsy;
    @(posedge CLK);
    for (int k = 1; k <= 40; k++) begin
      #1;
      tr_bus[k] = B_BUS_OUT; tr_add[k] = A_ADD; tr_util[k] = B_UTIL; tr_req[k] = B_REQ;
      tr_done[k] = M_DONE; tr_split[k] = M_SPLIT; tr_err[k] = M_ERR; tr_rdy[k] = M_RDY;
      if (k == rst_k) begin
        #2 RSTN = 1'b0;
        #1;
        check("rst_util", 32'(B_UTIL),    32'd0);
        check("rst_aadd", 32'(A_ADD),     32'd0);
        check("rst_bus",  32'(B_BUS_OUT), 32'd0);
        check("rst_breq", 32'(B_REQ),     32'd0);
        check("rst_rdy",  32'(M_RDY),     32'd1);
        check("rst_done", 32'(M_DONE),    32'd0);
      end
      @(negedge CLK);
      RSTN    = 1'b1;
      M_REQ   = (k < noise_end) ? 1'($urandom_range(1, 0)) : 1'b0;
      M_SLAVE = SB'($urandom);
      M_ADDR  = AW'($urandom);
      B_GRANT = (k >= gdelay);
      if (b2b && k == gdelay + 16) begin
        M_REQ = 1'b1; M_SLAVE = slv2; M_ADDR = addr2;
      end
      @(posedge CLK);
    end
    @(negedge CLK);
    M_REQ = 1'b0;
  endtask

  logic [FL-1:0] fr_v;

  initial begin
    RSTN = 1'b0; M_REQ = 1'b0; M_SLAVE = '0; M_ADDR = '0; B_GRANT = 1'b0; B_SBSY = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_rdy",  32'(M_RDY),     32'd1);
    check("reset_breq", 32'(B_REQ),     32'd0);
    check("reset_util", 32'(B_UTIL),    32'd0);
    check("reset_aadd", 32'(A_ADD),     32'd0);
    check("reset_bus",  32'(B_BUS_OUT), 32'd0);
    check("reset_puls", 32'({M_DONE, M_SPLIT, M_ERR}), 32'd0);
    RSTN = 1'b1;
    chk_en = 1'b1;

    // Normal frame, immediate grant; busy flag high but ignored for ID 2.
    txn(2'd2, 12'hA5C, 1, 1'b1, 0, 1'b0, '0, '0, 0);
    for (int i = 0; i < FL; i++) fr_v[i] = frame[i];
    check("model_frame", 32'(fr_v),          32'h52E2);
    check("norm_bus",    32'(tr_bus[16:2]),  32'h52E2);
    check("norm_aadd",   32'(tr_add[16:2]),  32'h7FFB);
    check("norm_breq",   32'(tr_req[1]),     32'd1);
    check("norm_done17", 32'(tr_done[17]),   32'd1);
    check("norm_rdy17",  32'(tr_rdy[17]),    32'd1);
    check("norm_util17", 32'(tr_util[17]),   32'd0);
    check("norm_ndone",  32'($countones(tr_done)), 32'd1);

    // Delayed grant: five arbitration cycles.
    txn(2'd3, 12'h5A3, 5, 1'b0, 0, 1'b0, '0, '0, 0);
    check("dly_breq_n", 32'($countones(tr_req)), 32'd5);
    check("dly_util",   32'(tr_util[5:1]),       32'd0);
    check("dly_addr",   32'(tr_bus[20:9]),       32'h5A3);
    check("dly_done",   32'(tr_done[21]),        32'd1);

    // Split slave busy in the check slot, then not busy.
    txn(2'd1, 12'h0F0, 1, 1'b1, 0, 1'b0, '0, '0, 0);
    check("spl_pulse", 32'(tr_split[5]),          32'd1);
    check("spl_util",  32'(tr_util[5]),           32'd0);
    check("spl_rdy",   32'(tr_rdy[5]),            32'd1);
    check("spl_naadd", 32'($countones(tr_add)),   32'd2);
    check("spl_ndone", 32'($countones(tr_done)),  32'd0);
    txn(2'd1, 12'h0F0, 1, 1'b0, 0, 1'b0, '0, '0, 0);
    check("nospl_done", 32'(tr_done[17]),         32'd1);
    check("nospl_nspl", 32'($countones(tr_split)), 32'd0);
    check("nospl_addr", 32'(tr_bus[16:5]),        32'h0F0);

    // Invalid slave ID.
    txn(2'd0, 12'h123, 1, 1'b0, 0, 1'b0, '0, '0, 0);
    check("err_pulse", 32'(tr_err[1]),            32'd1);
    check("err_rdy",   32'(tr_rdy[1]),            32'd1);
    check("err_nreq",  32'($countones(tr_req)),   32'd0);
    check("err_nerr",  32'($countones(tr_err)),   32'd1);

    // Request noise while busy, then back-to-back request in the done cycle.
    txn(2'd2, 12'h8E1, 1, 1'b0, 16, 1'b1, 2'd3, 12'h3C1, 0);
    check("b2b_addr1", 32'(tr_bus[16:5]),   32'h8E1);
    check("b2b_done1", 32'(tr_done[17]),    32'd1);
    check("b2b_breq",  32'(tr_req[18]),     32'd1);
    check("b2b_slv2",  32'(tr_bus[20:19]),  32'd3);
    check("b2b_addr2", 32'(tr_bus[33:22]),  32'h3C1);
    check("b2b_done2", 32'(tr_done[34]),    32'd1);

    // Asynchronous reset during address bit 5, then a clean transaction.
    txn(2'd2, 12'hFFF, 1, 1'b0, 0, 1'b0, '0, '0, 10);
    check("rst_nodone", 32'($countones(tr_done[40:11])), 32'd0);
    check("rst_nobus",  32'($countones(tr_util[40:11])), 32'd0);
    txn(2'd3, 12'h123, 1, 1'b0, 0, 1'b0, '0, '0, 0);
    check("post_rst_addr", 32'(tr_bus[16:5]), 32'h123);
    check("post_rst_done", 32'(tr_done[17]),  32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      M_REQ   = ($urandom_range(2, 0) == 0);
      M_SLAVE = SB'($urandom);
      M_ADDR  = AW'($urandom);
      B_GRANT = 1'($urandom_range(1, 0));
      B_SBSY  = 1'($urandom_range(1, 0));
    end
    @(negedge CLK);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
